// File: rtl/student_fir_par_pkg.sv
// Shared types and helpers for the student_fir_par parallel FIR.
// Holds the state enum, the width helpers and the saturate/truncate function.
package student_fir_par_pkg;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StMac,
        StDrain,
        StOut
    } fir_par_state_t;

    localparam int unsigned WIDE_W = 64;

    typedef struct packed {
        logic [WIDE_W-1:0] value;
        logic              sat;
    } sat_res_t;

    function automatic int unsigned calc_steps(input int unsigned taps, input int unsigned lanes);
        return taps / lanes;
    endfunction

    function automatic int unsigned calc_row_w(input int unsigned steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

    function automatic int unsigned calc_step_w(input int unsigned steps);
        return $clog2(steps + 1);
    endfunction

    function automatic int unsigned calc_lane_w(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    // Clamp v to the signed out_w range when sat_en is set; the caller keeps the low out_w bits.
    function automatic sat_res_t sat_trunc(input logic signed [WIDE_W-1:0] v,
                                           input int unsigned out_w,
                                           input logic sat_en);
        sat_res_t r;
        logic signed [WIDE_W-1:0] vmin;
        logic signed [WIDE_W-1:0] vmax;
        vmin    = -(64'sd1 <<< (out_w - 1));
        vmax    = ~vmin;
        r.value = v;
        r.sat   = 1'b0;
        if (sat_en && (v > vmax)) begin
            r.value = vmax;
            r.sat   = 1'b1;
        end else if (sat_en && (v < vmin)) begin
            r.value = vmin;
            r.sat   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/student_fir_par_lane.sv
// One multiplier lane: a history bank, a coefficient bank (both 1-cycle read)
// and a signed multiplier feeding a product register.
module student_fir_par_lane #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned COEFF_W = 16,
    parameter int unsigned STEPS   = 16,
    parameter int unsigned ROW_W   = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              hist_we,
    input  logic [ROW_W-1:0]                  hist_waddr,
    input  logic signed [DATA_W-1:0]          hist_wdata,
    input  logic [ROW_W-1:0]                  hist_raddr,
    input  logic                              coef_we,
    input  logic [ROW_W-1:0]                  coef_waddr,
    input  logic signed [COEFF_W-1:0]         coef_wdata,
    input  logic [ROW_W-1:0]                  coef_raddr,
    output logic signed [COEFF_W-1:0]         coef_rdata,
    input  logic signed [COEFF_W-1:0]         coef_sel,
    output logic signed [DATA_W+COEFF_W-1:0]  prod
);

    logic signed [DATA_W-1:0]         hist_mem [STEPS];
    logic signed [COEFF_W-1:0]        coef_mem [STEPS];
    logic signed [DATA_W-1:0]         hist_rd_q;
    logic signed [COEFF_W-1:0]        coef_rd_q;
    logic signed [DATA_W+COEFF_W-1:0] prod_q;

    always_ff @(posedge clk) begin
        if (hist_we) begin
            hist_mem[hist_waddr] <= hist_wdata;
        end
        if (coef_we) begin
            coef_mem[coef_waddr] <= coef_wdata;
        end
    end

    // Write-first reads: the newest sample is read on the same edge it is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_rd_q <= '0;
            coef_rd_q <= '0;
            prod_q    <= '0;
        end else begin
            hist_rd_q <= (hist_we && (hist_waddr == hist_raddr)) ? hist_wdata
                                                                  : hist_mem[hist_raddr];
            coef_rd_q <= (coef_we && (coef_waddr == coef_raddr)) ? coef_wdata
                                                                  : coef_mem[coef_raddr];
            prod_q    <= hist_rd_q * coef_sel;
        end
    end

    assign coef_rdata = coef_rd_q;
    assign prod       = prod_q;

endmodule

// File: rtl/student_fir_par.sv
// LANES-way parallel signed FIR with valid/ready streams and a coefficient write port.
// Define STUDENT_FIR_PAR_SATURATE_EN to clamp out-of-range results and enable sticky sat_o.
module student_fir_par
    import student_fir_par_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned COEFF_W   = 16,
    parameter int unsigned NUM_TAPS  = 64,
    parameter int unsigned LANES     = 4,
    parameter int unsigned ACC_W     = 40,
    parameter int unsigned OUT_W     = 32,
    parameter int unsigned OUT_SHIFT = 15
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        s_valid_i,
    output logic                        s_ready_o,
    input  logic signed [DATA_W-1:0]    s_data_i,
    output logic                        m_valid_o,
    input  logic                        m_ready_i,
    output logic [OUT_W-1:0]            m_data_o,
    input  logic                        coef_we_i,
    input  logic [$clog2(NUM_TAPS)-1:0] coef_addr_i,
    input  logic signed [COEFF_W-1:0]   coef_wdata_i,
    input  logic                        clr_i,
    output logic                        busy_o,
    output logic                        sat_o
);

    localparam int unsigned STEPS   = calc_steps(NUM_TAPS, LANES);
    localparam int unsigned ROW_W   = calc_row_w(STEPS);
    localparam int unsigned STEP_W  = calc_step_w(STEPS);
    localparam int unsigned LANE_W  = calc_lane_w(LANES);
    localparam int unsigned PTR_W   = $clog2(NUM_TAPS);
    localparam int unsigned PROD_W  = DATA_W + COEFF_W;
    localparam int unsigned RND_POS = (OUT_SHIFT == 0) ? 0 : OUT_SHIFT - 1;
    localparam logic signed [ACC_W:0] RND = (OUT_SHIFT == 0) ? '0 : ((ACC_W+1)'(1) << RND_POS);
`ifdef STUDENT_FIR_PAR_SATURATE_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    fir_par_state_t state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [ROW_W-1:0]  init_row_q, init_row_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              busy_q;

    logic              take_sample;
    logic              issue;
    logic              coef_ok;
    logic [ROW_W-1:0]  ptr_row;
    logic [LANE_W-1:0] lane_r;
    logic [ROW_W-1:0]  rd_step;
    logic [LANE_W-1:0] coef_lane;
    logic [ROW_W-1:0]  coef_row;

    logic [ROW_W-1:0]          hist_raddr [LANES];
    logic signed [COEFF_W-1:0] coef_rd    [LANES];
    logic signed [COEFF_W-1:0] coef_sel   [LANES];
    logic signed [PROD_W-1:0]  prod       [LANES];

    logic                    rd_vld_q, prod_vld_q, tree_vld_q;
    logic signed [ACC_W-1:0] tree_sum, tree_q, acc_q;
    logic signed [ACC_W:0]   acc_rnd, acc_sh;
    logic signed [WIDE_W-1:0] res_wide;
    sat_res_t                sr;
    logic                    unused_sat;

    assign take_sample = s_valid_i && (state_q == StIdle);
    assign coef_ok     = (state_q == StInit) || (state_q == StIdle);
    assign issue       = take_sample || ((state_q == StMac) && (step_q != STEP_W'(STEPS)));

    assign ptr_row   = ROW_W'(32'(wr_ptr_q) / LANES);
    assign lane_r    = LANE_W'(32'(wr_ptr_q) % LANES);
    assign rd_step   = (state_q == StMac) ? ROW_W'(step_q) : '0;
    assign coef_lane = LANE_W'(32'(coef_addr_i) % LANES);
    assign coef_row  = ROW_W'(32'(coef_addr_i) / LANES);

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        init_row_d = init_row_q;
        wr_ptr_d   = wr_ptr_q;
        unique case (state_q)
            StInit: begin
                init_row_d = init_row_q + 1'b1;
                if (init_row_q == ROW_W'(STEPS - 1)) begin
                    init_row_d = '0;
                    state_d    = StIdle;
                end
            end
            StIdle: begin
                if (take_sample) begin
                    step_d  = STEP_W'(1);
                    state_d = StMac;
                end else if (clr_i) begin
                    state_d = StInit;
                end
            end
            StMac: begin
                if (step_q == STEP_W'(STEPS)) begin
                    step_d  = '0;
                    state_d = StDrain;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            StDrain: begin
                if (step_q == STEP_W'(1)) begin
                    step_d  = '0;
                    state_d = StOut;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            StOut: begin
                if (m_ready_i) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StInit;
            step_q     <= '0;
            init_row_q <= '0;
            wr_ptr_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            init_row_q <= init_row_d;
            wr_ptr_q   <= wr_ptr_d;
            busy_q     <= (state_d != StIdle);
        end
    end

    // Lane b holds samples with address%LANES == b; its coefficient comes from the lane
    // whose tap index lines up with that sample, so coefficients are rotated by wr_ptr.
    for (genvar b = 0; b < LANES; b++) begin : g_lane
        logic              borrow;
        logic              hist_we;
        logic              coef_we;
        logic [ROW_W-1:0]  hist_waddr;
        logic signed [DATA_W-1:0] hist_wdata;

        assign borrow        = (32'(lane_r) < b);
        assign hist_raddr[b] = ROW_W'((32'(ptr_row) + 2 * STEPS - 32'(borrow) - 32'(rd_step))
                                      % STEPS);
        assign coef_sel[b]   = coef_rd[LANE_W'((32'(lane_r) + LANES - b) % LANES)];
        assign hist_we       = (state_q == StInit) || (take_sample && (lane_r == LANE_W'(b)));
        assign hist_waddr    = (state_q == StInit) ? init_row_q : ptr_row;
        assign hist_wdata    = (state_q == StInit) ? '0 : s_data_i;
        assign coef_we       = coef_ok && coef_we_i && (coef_lane == LANE_W'(b));

        student_fir_par_lane #(
            .DATA_W  (DATA_W),
            .COEFF_W (COEFF_W),
            .STEPS   (STEPS),
            .ROW_W   (ROW_W)
        ) u_lane (
            .clk        (clk_i),
            .rst_n      (rst_ni),
            .hist_we    (hist_we),
            .hist_waddr (hist_waddr),
            .hist_wdata (hist_wdata),
            .hist_raddr (hist_raddr[b]),
            .coef_we    (coef_we),
            .coef_waddr (coef_row),
            .coef_wdata (coef_wdata_i),
            .coef_raddr (rd_step),
            .coef_rdata (coef_rd[b]),
            .coef_sel   (coef_sel[b]),
            .prod       (prod[b])
        );
    end

    always_comb begin
        tree_sum = '0;
        for (int b = 0; b < LANES; b++) begin
            tree_sum = tree_sum + ACC_W'(prod[b]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_vld_q   <= 1'b0;
            prod_vld_q <= 1'b0;
            tree_vld_q <= 1'b0;
            tree_q     <= '0;
            acc_q      <= '0;
        end else begin
            rd_vld_q   <= issue;
            prod_vld_q <= rd_vld_q;
            tree_vld_q <= prod_vld_q;
            tree_q     <= tree_sum;
            if (take_sample) begin
                acc_q <= '0;
            end else if (tree_vld_q) begin
                acc_q <= acc_q + tree_q;
            end
        end
    end

    assign acc_rnd  = (ACC_W+1)'(acc_q) + RND;
    assign acc_sh   = acc_rnd >>> OUT_SHIFT;
    assign res_wide = WIDE_W'(acc_sh);
    assign sr       = sat_trunc(res_wide, OUT_W, SAT_EN);

    assign s_ready_o  = (state_q == StIdle);
    assign m_valid_o  = (state_q == StOut);
    assign m_data_o   = (state_q == StOut) ? sr.value[OUT_W-1:0] : '0;
    assign busy_o     = busy_q;
    assign unused_sat = ^{sr.value >> OUT_W, sr.sat};

`ifdef STUDENT_FIR_PAR_SATURATE_EN
    logic sat_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_q <= 1'b0;
        end else if ((state_q == StOut) && sr.sat) begin
            sat_q <= 1'b1;
        end
    end
    assign sat_o = sat_q;
`else
    assign sat_o = 1'b0;
`endif

endmodule

// File: tb/tb_student_fir_par.sv
// Directed scoreboard bench for student_fir_par (8 taps, 2 lanes, no shift);
// a second 16-bit-output instance runs in lockstep to cover saturation/wrap.
module tb_student_fir_par;

    localparam int unsigned NT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic signed [15:0] s_data;
    logic        m_ready;
    logic        coef_we;
    logic [2:0]  coef_addr;
    logic signed [15:0] coef_wdata;
    logic        clr;

    logic        s_ready, m_valid, busy, sat;
    logic [31:0] m_data;
    logic        s_ready16, m_valid16, busy16, sat16;
    logic [15:0] m_data16;

    int compared   = 0;
    int mismatched = 0;

    longint      hist_m [NT];
    longint      h_m    [NT];
    logic [31:0] q32 [$];
    logic [15:0] q16 [$];

    always #5 clk = ~clk;

    student_fir_par #(
        .DATA_W(16), .COEFF_W(16), .NUM_TAPS(NT), .LANES(2),
        .ACC_W(40), .OUT_W(32), .OUT_SHIFT(0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
        .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_wdata_i(coef_wdata),
        .clr_i(clr), .busy_o(busy), .sat_o(sat)
    );

    student_fir_par #(
        .DATA_W(16), .COEFF_W(16), .NUM_TAPS(NT), .LANES(2),
        .ACC_W(40), .OUT_W(16), .OUT_SHIFT(0)
    ) dut16 (
        .clk_i(clk), .rst_ni(rst_n),
        .s_valid_i(s_valid), .s_ready_o(s_ready16), .s_data_i(s_data),
        .m_valid_o(m_valid16), .m_ready_i(m_ready), .m_data_o(m_data16),
        .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_wdata_i(coef_wdata),
        .clr_i(clr), .busy_o(busy16), .sat_o(sat16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp16_of(input longint f);
`ifdef STUDENT_FIR_PAR_SATURATE_EN
        if (f > 32767) return 16'h7fff;
        if (f < -32768) return 16'h8000;
`endif
        return f[15:0];
    endfunction

    task automatic push_sample(input longint x);
        longint f;
        for (int k = NT - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
        hist_m[0] = x;
        f = 0;
        for (int k = 0; k < NT; k++) f += h_m[k] * hist_m[k];
        q32.push_back(f[31:0]);
        q16.push_back(exp16_of(f));
    endtask

    task automatic clear_model();
        for (int k = 0; k < NT; k++) hist_m[k] = 0;
    endtask

    task automatic write_coef(input int k, input longint v);
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = 3'(k);
        coef_wdata = 16'(v);
        h_m[k]     = v;
        @(negedge clk);
        coef_we    = 1'b0;
    endtask

    task automatic reset_release();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("init_ready", s_ready, 1'b0);
            check("init_valid", m_valid | m_valid16, 1'b0);
            if (i > 0) check("init_busy", busy, 1'b1);
        end
        @(negedge clk);
        check("idle_ready", s_ready, 1'b1);
        check("idle_busy", busy, 1'b0);
    endtask

    task automatic run_sample(input longint x, input int bp, input bit coef_in_mac);
        int n;
        int lat;
        logic [31:0] e32;
        logic [15:0] e16;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", n < 40, 1'b1);
        s_valid = 1'b1;
        s_data  = x[15:0];
        m_ready = (bp == 0);
        push_sample(x);
        @(negedge clk);
        s_valid = 1'b0;
        lat = 1;
        if (coef_in_mac) begin
            coef_we    = 1'b1;
            coef_addr  = 3'd0;
            coef_wdata = 16'sd100;
            @(negedge clk);
            coef_we = 1'b0;
            lat++;
        end
        while (!m_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 7);
        check("valid16", m_valid16, 1'b1);
        check("sb_size", q32.size(), 1);
        e32 = (q32.size() > 0) ? q32.pop_front() : 32'hx;
        e16 = (q16.size() > 0) ? q16.pop_front() : 16'hx;
        for (int i = 0; i < bp; i++) begin
            check("bp_data", m_data, e32);
            check("bp_ready", s_ready, 1'b0);
            check("bp_valid", m_valid, 1'b1);
            @(negedge clk);
        end
        m_ready = 1'b1;
        check("m_data", m_data, e32);
        check("m_data16", m_data16, e16);
        @(negedge clk);
        check("ready_after", s_ready, 1'b1);
        check("valid_after", m_valid, 1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        m_ready    = 1'b1;
        coef_we    = 1'b0;
        coef_addr  = '0;
        coef_wdata = '0;
        clr        = 1'b0;
        clear_model();
        for (int k = 0; k < NT; k++) h_m[k] = 0;

        // Reset state and INIT length.
        repeat (3) @(negedge clk);
        check("rst_valid", m_valid, 1'b0);
        check("rst_ready", s_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_data", m_data, 32'd0);
        check("rst_sat", sat16, 1'b0);
        reset_release();

        // Impulse response with h[k] = k+1.
        for (int k = 0; k < NT; k++) write_coef(k, k + 1);
        run_sample(1, 0, 1'b0);
        for (int i = 0; i < NT; i++) run_sample(0, 0, 1'b0);

        // Backpressure, then a follow-up sample.
        run_sample(7, 5, 1'b0);
        run_sample(3, 0, 1'b0);

        // Signed extremes: saturation / wrap on the 16-bit instance.
        for (int k = 0; k < NT; k++) write_coef(k, -1);
        for (int i = 0; i < NT; i++) run_sample(-32768, 0, 1'b0);
`ifdef STUDENT_FIR_PAR_SATURATE_EN
        check("sat16", sat16, 1'b1);
`else
        check("sat16", sat16, 1'b0);
`endif
        check("sat32", sat, 1'b0);

        // Coefficient write during MAC is dropped.
        for (int k = 0; k < NT; k++) write_coef(k, k + 1);
        run_sample(1, 0, 1'b1);
        run_sample(2, 0, 1'b0);

        // clr_i in IDLE reruns INIT and zeroes history.
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("clr_init", s_ready, 1'b0);
            @(negedge clk);
        end
        check("clr_idle", s_ready, 1'b1);
        clear_model();
        write_coef(0, 3);
        run_sample(5, 0, 1'b0);

        // Reset pulsed mid-MAC.
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 16'sd4;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mac_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", m_valid, 1'b0);
        check("midrst_ready", s_ready, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_data", m_data, 32'd0);
        clear_model();
        reset_release();
        run_sample(2, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

endmodule
